gameport_paddles: RTL and testbench
===================================

Name: gameport_paddles

Overview:
- Parametrised Apple II game-port paddle timer: the 555-timer emulation generalised to NUM_PDL channels.
- Converts signed analog joystick samples into per-paddle "timer running" bits, i.e. the pdl0..pdl3 bits of GAMEPORT.
- Retriggered by the core's PDL_STROBE (C07x access); counts on CLK_2M rising edges sampled in the CLK_14M domain.
- Beyond the two-axis fixed-constant version, adds:
  - per-channel enable and invert;
  - parametrised centre, gain and clamp;
  - sample-and-hold of analog inputs at strobe;
  - an aggregate busy flag.

Parameters:
- NUM_PDL, 4, number of paddle channels (1..4).
- AN_W, 8, width of each signed analog sample.
- CNT_W, 13, counter width; must hold MAX_COUNT.
- CENTER, 2800, tick count for analog value 0.
- GAIN, 22, ticks per analog LSB.
- CLAMP_HI, 5590, load values at or above this are replaced by MAX_COUNT.
- MAX_COUNT, 5650, full-scale tick count.
- INVERT, 4'b0000, per-channel bit; 1 means the analog sample is negated before scaling.
- DEADZONE, 4, dead-zone half-width in LSBs (used only with the optional feature).

Ports:
- CLK_14M  input  1  14.31818 MHz master clock.
- reset_n  input  1  asynchronous, active-low reset.
- CLK_2M  input  1  core CPU clock; its rising edge, sampled in CLK_14M, is the count tick.
- pdl_strobe  input  1  high while C07x is accessed; retriggers all enabled channels.
- pdl_en  input  NUM_PDL  per-channel enable.
- joy_an  input  NUM_PDL*AN_W  signed samples; channel i occupies [i*AN_W +: AN_W].
- pdl_out  output  NUM_PDL  timer-running bits to GAMEPORT.
- busy  output  1  OR of pdl_out.

Behaviour:
- Reset (reset_n low, asynchronous): all counters 0, pdl_out 0, busy 0, edge-detect register 0, held samples 0.
- Tick detection:
  - clk2_d is registered from CLK_2M.
  - tick = CLK_2M & ~clk2_d.
  - All channel updates happen only on CLK_14M edges where tick = 1.
- Per channel i on a tick, evaluated in this order:
  - pdl_out[i] <= en & (cnt[i] != 0); the output reflects the pre-update count.
  - If cnt[i] != 0, then cnt[i] <= cnt[i] - 1.
  - If pdl_strobe = 1 and pdl_en[i] = 1:
    - latch joy_an slice into held[i];
    - cnt[i] <= load(joy_an slice).
    - The load overrides the decrement.
  - If pdl_en[i] = 0: cnt[i] <= 0 and pdl_out[i] <= 0, regardless of strobe.
- Load arithmetic, signed, at least CNT_W + AN_W + 6 bits internally:
  - s = INVERT[i] ? -a : a, where -(most-negative) saturates to +max (e.g. -(-128) = 127).
  - v = CENTER + GAIN*s.
  - v < 0 gives 0; v >= CLAMP_HI gives MAX_COUNT; otherwise v.
- Resulting pulse:
  - pdl_out high for exactly load ticks, starting the tick after the strobe tick.
  - Load 0 gives no pulse.
- Strobe held high across several ticks: reload on every such tick, so the pulse is extended.
- Strobe while running: restart from the new load value; no glitch low on pdl_out.
- busy is combinational OR of the registered pdl_out.
- Counter never wraps below 0.
- Reset mid-pulse: output drops immediately (asynchronous).

Optional Feature:
- Macro GAMEPORT_DEADZONE_EN.
- When defined: before inversion, any sample with |a| <= DEADZONE is treated as 0, so the load is exactly CENTER.
- When undefined: no dead zone; the DEADZONE parameter is ignored.

Test Plan:
- Reset release, no strobe, 100 ticks -> pdl_out = 0, busy = 0 throughout.
- Channel 0: an = 0, enabled, single-tick strobe -> pdl_out[0] high for exactly 2800 ticks, beginning the tick after the strobe tick.
- Channel 1 = +127, channel 2 = -128 -> channel 1 clamps to 5650 ticks; channel 2 loads 0 (2800 - 2816 < 0), so no pulse.
- INVERT = 4'b0001, channel 0 an = +10 -> pulse 2580 ticks.
- Re-strobe at tick 1000 of a 2800-tick pulse with an = 0 -> pdl_out stays high, falls 2800 ticks after the second strobe.
- pdl_en[3] = 0 with strobe -> pdl_out[3] = 0.
- With GAMEPORT_DEADZONE_EN and an = +3 -> 2800 ticks; without the macro -> 2866 ticks.
- Assert reset_n mid-pulse -> pdl_out = 0 immediately.

Source files
------------

// File: rtl/gameport_paddles.sv
// gameport_paddles
//   Apple II game-port paddle timer. Each channel emulates one 555 one-shot:
//   a strobe loads a tick count derived from a signed analog sample, and the
//   channel's output bit stays high while that count runs down to zero.
//   Counting advances on rising edges of CLK_2M, detected in the CLK_14M domain.
//
//   Optional build macro: GAMEPORT_DEADZONE_EN
//     defined   -> samples with |a| <= DEADZONE load exactly CENTER
//     undefined -> no dead zone (DEADZONE is only range-checked)
//
// Ports
//   CLK_14M     in   1               master clock
//   reset_n     in   1               asynchronous active-low reset
//   CLK_2M      in   1               CPU clock; its rising edge is the count tick
//   pdl_strobe  in   1               C07x access; reloads every enabled channel
//   pdl_en      in   NUM_PDL         per-channel enable
//   joy_an      in   NUM_PDL*AN_W    signed samples, channel i at [i*AN_W +: AN_W]
//   pdl_out     out  NUM_PDL         timer-running bits (pdl0..pdl3 of GAMEPORT)
//   busy        out  1               OR of pdl_out
module gameport_paddles #(
  parameter int unsigned NUM_PDL   = 4,
  parameter int unsigned AN_W      = 8,
  parameter int unsigned CNT_W     = 13,
  parameter int          CENTER    = 2800,
  parameter int          GAIN      = 22,
  parameter int          CLAMP_HI  = 5590,
  parameter int          MAX_COUNT = 5650,
  parameter logic [3:0]  INVERT    = 4'b0000,
  parameter int          DEADZONE  = 4
) (
  input  logic                    CLK_14M,
  input  logic                    reset_n,
  input  logic                    CLK_2M,
  input  logic                    pdl_strobe,
  input  logic [NUM_PDL-1:0]      pdl_en,
  input  logic [NUM_PDL*AN_W-1:0] joy_an,
  output logic [NUM_PDL-1:0]      pdl_out,
  output logic                    busy
);

  // Internal arithmetic width: wide enough that CENTER + GAIN*s never overflows.
  localparam int unsigned LW = CNT_W + AN_W + 6;

  localparam logic signed [LW-1:0] CENTER_S = LW'(CENTER);
  localparam logic signed [LW-1:0] GAIN_S   = LW'(GAIN);
  localparam logic signed [LW-1:0] CLAMP_S  = LW'(CLAMP_HI);
  localparam logic signed [LW-1:0] AMAX_S   = LW'((1 << (AN_W - 1)) - 1);
  localparam logic [CNT_W-1:0]     MAX_CNT  = CNT_W'(MAX_COUNT);
`ifdef GAMEPORT_DEADZONE_EN
  localparam logic signed [LW-1:0] DZ_S     = LW'(DEADZONE);
`endif

  // Elaboration-time parameter sanity checks.
  if (NUM_PDL < 1 || NUM_PDL > 4) begin : g_bad_num_pdl
    $error("gameport_paddles: NUM_PDL must be 1..4");
  end
  if (MAX_COUNT >= (1 << CNT_W) || MAX_COUNT < 0) begin : g_bad_cnt_w
    $error("gameport_paddles: CNT_W too narrow for MAX_COUNT");
  end
  if (DEADZONE < 0 || DEADZONE >= (1 << (AN_W - 1))) begin : g_bad_deadzone
    $error("gameport_paddles: DEADZONE out of sample range");
  end

  logic                 clk2_q;
  logic                 tick;
  logic [NUM_PDL-1:0]   pdl_out_q, pdl_out_d;
  logic [CNT_W-1:0]     cnt_q  [NUM_PDL];
  logic [CNT_W-1:0]     cnt_d  [NUM_PDL];
  logic [AN_W-1:0]      held_q [NUM_PDL];
  logic [AN_W-1:0]      held_d [NUM_PDL];

  // Sample -> tick count. Negating the most-negative sample saturates to +max
  // so an inverted full-left stick reads as full-right rather than wrapping.
  function automatic logic [CNT_W-1:0] load_val(input logic [AN_W-1:0] a,
                                                input logic            inv);
    logic signed [LW-1:0] a_s;
    logic signed [LW-1:0] s;
    logic signed [LW-1:0] v;
    logic                 a_min;
    a_s   = {{(LW-AN_W){a[AN_W-1]}}, a};
    a_min = (a == {1'b1, {(AN_W-1){1'b0}}});
`ifdef GAMEPORT_DEADZONE_EN
    if (((a_s[LW-1]) ? -a_s : a_s) <= DZ_S) begin
      a_s   = '0;
      a_min = 1'b0;
    end
`endif
    if (inv) s = a_min ? AMAX_S : -a_s;
    else     s = a_s;
    v = CENTER_S + GAIN_S * s;
    if (v[LW-1])          load_val = '0;
    else if (v >= CLAMP_S) load_val = MAX_CNT;
    else                   load_val = v[CNT_W-1:0];
  endfunction

  assign tick = CLK_2M & ~clk2_q;

  // Per-channel update. Later assignments win: the strobe load overrides the
  // decrement, and a disabled channel is forced idle whatever else happened.
  always_comb begin
    pdl_out_d = pdl_out_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    if (tick) begin
      for (int unsigned i = 0; i < NUM_PDL; i++) begin
        pdl_out_d[i] = pdl_en[i] & (cnt_q[i] != '0);
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
        if (!pdl_en[i]) begin
          cnt_d[i]     = '0;
          pdl_out_d[i] = 1'b0;
        end else if (pdl_strobe) begin
          held_d[i] = joy_an[i*AN_W +: AN_W];
          cnt_d[i]  = load_val(joy_an[i*AN_W +: AN_W], INVERT[i]);
        end
      end
    end
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      clk2_q    <= 1'b0;
      pdl_out_q <= '0;
      for (int unsigned i = 0; i < NUM_PDL; i++) begin
        cnt_q[i]  <= '0;
        held_q[i] <= '0;
      end
    end else begin
      clk2_q    <= CLK_2M;
      pdl_out_q <= pdl_out_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
    end
  end

  assign pdl_out = pdl_out_q;
  assign busy    = |pdl_out_q;

endmodule

// File: tb/tb_gameport_paddles.sv
// tb_gameport_paddles
//   Directed bench for gameport_paddles (INVERT = 4'b0001). CLK_2M is driven
//   one rising edge per tick() call so every tick is placed exactly; outputs
//   are sampled on CLK_14M falling edges.
module tb_gameport_paddles;

  logic        CLK_14M = 1'b0;
  logic        reset_n = 1'b0;
  logic        CLK_2M  = 1'b0;
  logic        pdl_strobe = 1'b0;
  logic [3:0]  pdl_en = '0;
  logic [31:0] joy_an = '0;
  logic [3:0]  pdl_out;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned hi_cnt   [4];
  int unsigned first_hi [4];
  int unsigned last_hi  [4];
  int unsigned busy_cnt;

`ifdef GAMEPORT_DEADZONE_EN
  localparam int unsigned CH1_PLUS3 = 2800;
`else
  localparam int unsigned CH1_PLUS3 = 2866;
`endif

  gameport_paddles #(
    .NUM_PDL (4),
    .AN_W    (8),
    .INVERT  (4'b0001)
  ) dut (
    .CLK_14M    (CLK_14M),
    .reset_n    (reset_n),
    .CLK_2M     (CLK_2M),
    .pdl_strobe (pdl_strobe),
    .pdl_en     (pdl_en),
    .joy_an     (joy_an),
    .pdl_out    (pdl_out),
    .busy       (busy)
  );

  always #35 CLK_14M = ~CLK_14M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One CLK_2M rising edge; returns on a falling edge of CLK_14M.
  task automatic tick();
    @(negedge CLK_14M) CLK_2M = 1'b1;
    @(negedge CLK_14M) CLK_2M = 1'b0;
  endtask

  task automatic strobe_tick();
    pdl_strobe = 1'b1;
    tick();
    pdl_strobe = 1'b0;
  endtask

  // Run nticks ticks (strobe on tick restrobe_at, 0 = none) and record, per
  // channel, how many ticks the output was high and the first/last such tick.
  task automatic measure(input int unsigned nticks, input int unsigned restrobe_at);
    for (int c = 0; c < 4; c++) begin
      hi_cnt[c] = 0; first_hi[c] = 0; last_hi[c] = 0;
    end
    busy_cnt = 0;
    for (int unsigned k = 1; k <= nticks; k++) begin
      pdl_strobe = (k == restrobe_at);
      tick();
      pdl_strobe = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      for (int c = 0; c < 4; c++) begin
        if (pdl_out[c] === 1'b1) begin
          hi_cnt[c]++;
          if (first_hi[c] == 0) first_hi[c] = k;
          last_hi[c] = k;
        end
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge CLK_14M);
    check("rst_out", 32'(pdl_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge CLK_14M) reset_n = 1'b1;

    // Idle: no strobe for 100 ticks
    measure(100, 0);
    check("idle_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 32'd0);
    check("idle_busy", busy_cnt, 32'd0);

    // ch0 +10 inverted -> 2580; ch1 +127 clamps -> 5650; ch2 -128 -> 0; ch3 disabled
    pdl_en = 4'b0111;
    joy_an = {8'h00, 8'h80, 8'h7F, 8'h0A};
    strobe_tick();
    check("B_strobe_out", 32'(pdl_out), 32'd0);
    measure(5700, 0);
    check("B_ch0_first", first_hi[0], 32'd1);
    check("B_ch0_len",   hi_cnt[0],   32'd2580);
    check("B_ch0_last",  last_hi[0],  32'd2580);
    check("B_ch1_first", first_hi[1], 32'd1);
    check("B_ch1_len",   hi_cnt[1],   32'd5650);
    check("B_ch1_last",  last_hi[1],  32'd5650);
    check("B_ch2_len",   hi_cnt[2],   32'd0);
    check("B_ch3_len",   hi_cnt[3],   32'd0);
    check("B_busy_len",  busy_cnt,    32'd5650);
    check("B_end_out",   32'(pdl_out), 32'd0);

    // ch0 an=0 (2800), ch1 an=+3; re-strobe on tick 1000 of the pulse
    pdl_en = 4'b0011;
    joy_an = {8'h00, 8'h00, 8'h03, 8'h00};
    strobe_tick();
    measure(4000, 1000);
    check("C_ch0_first", first_hi[0], 32'd1);
    check("C_ch0_len",   hi_cnt[0],   32'd3800);
    check("C_ch0_last",  last_hi[0],  32'd3800);
    check("C_ch1_len",   hi_cnt[1],   1000 + CH1_PLUS3);
    check("C_ch1_last",  last_hi[1],  1000 + CH1_PLUS3);

    // Strobe held over three ticks: pulse measured from the last one
    pdl_en = 4'b0001;
    joy_an = '0;
    pdl_strobe = 1'b1;
    tick();
    check("D_s1_out", 32'(pdl_out[0]), 32'd0);
    tick();
    check("D_s2_out", 32'(pdl_out[0]), 32'd1);
    tick();
    check("D_s3_out", 32'(pdl_out[0]), 32'd1);
    pdl_strobe = 1'b0;
    measure(2900, 0);
    check("D_ch0_first", first_hi[0], 32'd1);
    check("D_ch0_len",   hi_cnt[0],   32'd2800);

    // Asynchronous reset in the middle of a pulse
    pdl_en = 4'b1111;
    strobe_tick();
    measure(500, 0);
    check("E_pre_out",  32'(pdl_out), 32'hF);
    check("E_pre_busy", 32'(busy),    32'd1);
    #10 reset_n = 1'b0;
    #1;
    check("E_rst_out",  32'(pdl_out), 32'd0);
    check("E_rst_busy", 32'(busy),    32'd0);
    @(negedge CLK_14M) reset_n = 1'b1;
    measure(10, 0);
    check("E_post_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
